// File: rtl/vga_pkg.sv
// Raster timing description shared by the scan generator and the colour/sprite blocks.
// A timing set is a packed struct so that alternative modes can be passed as one parameter.
package vga_pkg;

  typedef struct packed {
    logic [9:0] h_active, h_fp, h_sync, h_bp;
    logic [9:0] v_active, v_fp, v_sync, v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_active: 10'd640, h_fp: 10'd16, h_sync: 10'd96, h_bp: 10'd48,
    v_active: 10'd480, v_fp: 10'd10, v_sync: 10'd2,  v_bp: 10'd33
  };

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  // Colour word layout {B, G, R}, 4 bits per channel.
  localparam int COLOR_W = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 0;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 8;

  function automatic logic [9:0] h_total(input vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [9:0] v_total(input vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  function automatic logic [9:0] h_sync_start(input vga_timing_t t);
    return t.h_active + t.h_fp;
  endfunction

  function automatic logic [9:0] h_sync_end(input vga_timing_t t);
    return t.h_active + t.h_fp + t.h_sync - 10'd1;
  endfunction

  function automatic logic [9:0] v_sync_start(input vga_timing_t t);
    return t.v_active + t.v_fp;
  endfunction

  function automatic logic [9:0] v_sync_end(input vga_timing_t t);
    return t.v_active + t.v_fp + t.v_sync - 10'd1;
  endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Scan-position / colour / VGA-pin bundle between vga_scan and its colour source.
interface vga_scan_if;
  import vga_pkg::*;

  logic [COLOR_W-1:0] pix_color;
  logic [8:0]         row;
  logic [9:0]         col;
  logic               active;
  logic               pix_tick;
  logic               frame_start;
  logic               hs;
  logic               vs;
  logic [CH_W-1:0]    r;
  logic [CH_W-1:0]    g;
  logic [CH_W-1:0]    b;

  modport master (
    input  pix_color,
    output row, col, active, pix_tick, frame_start, hs, vs, r, g, b
  );

  modport slave (
    output pix_color,
    input  row, col, active, pix_tick, frame_start, hs, vs, r, g, b
  );

endinterface

// File: rtl/pix_clk_en.sv
// Pixel clock enable: divides clk by CLK_DIV and strobes pix_tick on the last count.
module pix_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (div_reg == LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign pix_tick = (div_reg == LAST);

endmodule

// File: rtl/vga_scan.sv
// Raster scan generator: drives row/col to the colour source, then registers its colour
// together with hs/vs one pixel later so that sync and RGB leave the chip aligned.
module vga_scan
  import vga_pkg::*;
#(
  parameter int          CLK_DIV  = 4,
  parameter int          PIX_LAT  = 1,
  parameter logic        SYNC_POL = 1'b0,
  parameter vga_timing_t TIMING   = VGA_640X480
) (
  input  logic       clk,
  input  logic       rst,
  vga_scan_if.master bus
);

  localparam logic [9:0] H_LAST    = h_total(TIMING) - 10'd1;
  localparam logic [9:0] V_LAST    = v_total(TIMING) - 10'd1;
  localparam logic [9:0] HS_START  = h_sync_start(TIMING);
  localparam logic [9:0] HS_END    = h_sync_end(TIMING);
  localparam logic [9:0] VS_START  = v_sync_start(TIMING);
  localparam logic [9:0] VS_END    = v_sync_end(TIMING);

  // The colour source gets CLK_DIV-1 clocks to answer; anything slower cannot work.
  if (CLK_DIV <= PIX_LAT) begin : g_bad_clk_div
    $error("vga_scan: CLK_DIV must exceed PIX_LAT");
  end

  logic tick;

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (tick)
  );

  logic [9:0] h_cnt_reg, v_cnt_reg;
  logic [9:0] h_cnt_next, v_cnt_next;
  logic       h_wrap, v_wrap;
  logic       active_next, hs_next, vs_next;

  always_comb begin
    h_wrap     = (h_cnt_reg == H_LAST);
    v_wrap     = (v_cnt_reg == V_LAST);
    h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_wrap) begin
      v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
    end
    active_next = (h_cnt_next < TIMING.h_active) && (v_cnt_next < TIMING.v_active);
    hs_next     = (h_cnt_next >= HS_START && h_cnt_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_next     = (v_cnt_next >= VS_START && v_cnt_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (tick) begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Position stage loads the post-tick counter values, so it changes together with the counters.
  logic [8:0] row_reg;
  logic [9:0] col_reg;
  logic       active_reg, hs_pos_reg, vs_pos_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg    <= '0;
      col_reg    <= '0;
      active_reg <= 1'b0;
      hs_pos_reg <= ~SYNC_POL;
      vs_pos_reg <= ~SYNC_POL;
    end else if (tick) begin
      row_reg    <= active_next ? v_cnt_next[8:0] : '0;
      col_reg    <= active_next ? h_cnt_next : '0;
      active_reg <= active_next;
      hs_pos_reg <= hs_next;
      vs_pos_reg <= vs_next;
    end
  end

  logic [CH_W-1:0] r_reg, g_reg, b_reg;
  logic            hs_reg, vs_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg  <= '0;
      g_reg  <= '0;
      b_reg  <= '0;
      hs_reg <= ~SYNC_POL;
      vs_reg <= ~SYNC_POL;
    end else if (tick) begin
      r_reg  <= active_reg ? bus.pix_color[R_LSB +: CH_W] : '0;
      g_reg  <= active_reg ? bus.pix_color[G_LSB +: CH_W] : '0;
      b_reg  <= active_reg ? bus.pix_color[B_LSB +: CH_W] : '0;
      hs_reg <= hs_pos_reg;
      vs_reg <= vs_pos_reg;
    end
  end

  assign bus.row         = row_reg;
  assign bus.col         = col_reg;
  assign bus.active      = active_reg;
  assign bus.pix_tick    = tick;
  assign bus.frame_start = tick & h_wrap & v_wrap;
  assign bus.hs          = hs_reg;
  assign bus.vs          = vs_reg;
  assign bus.r           = r_reg;
  assign bus.g           = g_reg;
  assign bus.b           = b_reg;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: a full 640x480 instance plus a shrunken-raster instance, both checked
// every clock against an arithmetic model of the raster position derived from clocks since reset.
module tb_vga_scan;
  import vga_pkg::*;

  localparam vga_timing_t SMALL_T = '{
    h_active: 10'd40, h_fp: 10'd4, h_sync: 10'd6, h_bp: 10'd4,
    v_active: 10'd20, v_fp: 10'd2, v_sync: 10'd2, v_bp: 10'd3
  };

  typedef struct packed {
    logic       tick;
    logic       fs;
    logic [8:0] row;
    logic [9:0] col;
    logic       act;
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          mode = 0;
  logic [11:0] seed = 12'h000;
  int          n_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vga_scan_if bus_d ();
  vga_scan_if bus_s ();

  vga_scan u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  vga_scan #(
    .CLK_DIV  (3),
    .PIX_LAT  (1),
    .SYNC_POL (1'b1),
    .TIMING   (SMALL_T)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  function automatic logic [11:0] colour(input int m, input logic [11:0] s,
                                         input logic [8:0] row, input logic [9:0] col);
    case (m)
      0:       return 12'h0F0;
      1:       return {col[3:0], row[3:0], 4'h5};
      default: return 12'(row * 7 + col * 13) ^ s;
    endcase
  endfunction

  // Colour block emulation: registers once (PIX_LAT = 1).
  always @(posedge clk) begin
    bus_d.pix_color <= colour(mode, seed, bus_d.row, bus_d.col);
    bus_s.pix_color <= colour(mode, seed, bus_s.row, bus_s.col);
  end

  always @(posedge clk) n_cnt <= rst ? 0 : n_cnt + 1;

  // n = clocks since the last reset edge; k = pixel ticks already taken effect.
  function automatic obs_t model(input int n, input vga_timing_t t, input int div,
                                 input logic pol, input int m, input logic [11:0] s);
    obs_t        e;
    int          ht, vt, ft, k, p, h, v;
    logic [11:0] c;
    ht = int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    vt = int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    ft = ht * vt;
    k  = n / div;
    e  = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    e.tick = (n % div) == div - 1;
    p = k % ft;
    e.fs = e.tick && (p == ft - 1);
    if (k >= 1) begin
      h = p % ht;
      v = p / ht;
      if (h < int'(t.h_active) && v < int'(t.v_active)) begin
        e.act = 1'b1;
        e.row = 9'(v);
        e.col = 10'(h);
      end
    end
    if (k >= 2) begin
      p = (k - 1) % ft;
      h = p % ht;
      v = p / ht;
      if (h >= int'(t.h_active) + int'(t.h_fp) && h < int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync))
        e.hs = pol;
      if (v >= int'(t.v_active) + int'(t.v_fp) && v < int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync))
        e.vs = pol;
      if (h < int'(t.h_active) && v < int'(t.v_active)) begin
        c = colour(m, s, 9'(v), 10'(h));
        e.r = c[3:0];
        e.g = c[7:4];
        e.b = c[11:8];
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int n, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s n=%0d got=%h exp=%h", name, n, got, exp);
    end
  endtask

  initial begin
    obs_t od, os, ed, es, rst_d, rst_s;
    int   n, last_fs;
    last_fs = -1;
    rst_d = '0; rst_d.hs = 1'b1; rst_d.vs = 1'b1;
    rst_s = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n  = n_cnt;
      od = '{bus_d.pix_tick, bus_d.frame_start, bus_d.row, bus_d.col, bus_d.active,
             bus_d.hs, bus_d.vs, bus_d.r, bus_d.g, bus_d.b};
      os = '{bus_s.pix_tick, bus_s.frame_start, bus_s.row, bus_s.col, bus_s.active,
             bus_s.hs, bus_s.vs, bus_s.r, bus_s.g, bus_s.b};
      ed = model(n, VGA_640X480, 4, 1'b0, mode, seed);
      es = model(n, SMALL_T, 3, 1'b1, mode, seed);
      chk("model_full", n, 64'(od), 64'(ed));
      chk("model_small", n, 64'(os), 64'(es));
      if (n == 0) begin
        chk("reset_full", n, 64'(od), 64'(rst_d));
        chk("reset_small", n, 64'(os), 64'(rst_s));
        last_fs = -1;
      end
      if (os.fs) begin
        if (last_fs < 0) chk("first_frame_start", n, 64'(n), 64'd4373);
        else             chk("frame_period", n, 64'(n - last_fs), 64'd4374);
        last_fs = n;
      end
      if (mode == 0) begin
        if (n == 2)    chk("tick_not_yet", n, 64'(od.tick), 64'd0);
        if (n == 3)    chk("first_tick", n, 64'(od.tick), 64'd1);
        if (n == 8)    chk("g_only_col1", n, 64'({od.r, od.g, od.b}), 64'h0F0);
        if (n == 2563) chk("g_only_col639", n, 64'({od.r, od.g, od.b}), 64'h0F0);
        if (n == 2564) chk("blank_col640", n, 64'({od.r, od.g, od.b}), 64'h000);
        if (n == 2627) chk("hs_before", n, 64'(od.hs), 64'd1);
        if (n == 2628) chk("hs_start656", n, 64'(od.hs), 64'd0);
        if (n == 3011) chk("hs_last751", n, 64'(od.hs), 64'd0);
        if (n == 3012) chk("hs_after", n, 64'(od.hs), 64'd1);
        if (n == 3566) chk("vs_before", n, 64'(os.vs), 64'd0);
        if (n == 3567) chk("vs_line22", n, 64'(os.vs), 64'd1);
        if (n == 3891) chk("vs_line24", n, 64'(os.vs), 64'd0);
        if (n == 4373) chk("wrap_fs", n, 64'(os.fs), 64'd1);
        if (n == 4374) chk("wrap_pos", n, 64'({os.row, os.col, os.act}), 64'({9'd0, 10'd0, 1'b1}));
      end
      if (mode == 1 && n == 2856)
        chk("pix_r17_c33", n, 64'({os.r, os.g, os.b}), 64'h511);
    end
  end

  task automatic do_reset(input int len, input int m, input logic [11:0] s);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    mode = m;
    seed = s;
    repeat (len - 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    int len, cyc;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    $display("segment 0: mode=0 reset_len=5 cycles=5000");
    run(5000);
    do_reset(2, 1, 12'h000);
    $display("segment 1: mode=1 reset_len=2 cycles=3000");
    run(3000);
    for (int i = 0; i < 6; i++) begin
      len = (i == 0) ? 3 : int'($urandom_range(1, 4));
      cyc = int'($urandom_range(400, 6000));
      do_reset(len, 2, 12'($urandom));
      $display("segment %0d: mode=2 reset_len=%0d seed=%h cycles=%0d", i + 2, len, seed, cyc);
      run(cyc);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
